out_port_uart_tx: RTL and testbench
===================================

# out_port_uart_tx

Serial transmitter for one CPU output port. It sits directly downstream of `micro_controller`: `data_in` takes one `out_portN` byte and `strobe_in` takes the matching `out_strobe[N-1]` bit. Each accepted byte goes into a small FIFO, then leaves on `tx` as an 8N1 UART frame. This decouples single-cycle CPU OUT writes from slow serial output.

## Interface
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit. Must be ≥ 2.
- `FIFO_DEPTH`, default 8: FIFO entries. Must be a power of 2 and ≥ 2.
- `clk`  in  1: single clock; all logic is on the rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `data_in`  in  8: byte from the CPU output port.
- `strobe_in`  in  1: CPU output strobe for this port.
- `tx`  out  1: serial line; idles high.
- `busy`  out  1: high while the FIFO is non-empty or the FSM is not in IDLE.
- `fifo_full`  out  1: FIFO holds FIFO_DEPTH entries.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1: current number of FIFO entries.
- `overflow`  out  1: sticky flag, set when a write is dropped.

## Operation
- Write detect:
  - `strobe_q` registers `strobe_in`.
  - A write occurs on a cycle where `strobe_in & ~strobe_q` (rising edge), sampling `data_in` that cycle.
  - A strobe held high for many cycles writes exactly one byte.
- FIFO:
  - Circular buffer with wrapping read/write pointers.
  - A write when full is dropped, even if a pop occurs in the same cycle, and sets `overflow`.
  - A simultaneous write (not full) and pop both succeed; `fifo_count` is unchanged.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: `tx`=1. If the FIFO is non-empty, pop the head into the shift register, clear the bit counter, go to START.
  - START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA.
  - DATA: `tx`=shift[0]. Every CLKS_PER_BIT cycles, shift right and increment the bit count; after 8 bits go to STOP. Bits go out LSB first.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles, then go to IDLE.
- Baud counter:
  - Width $clog2(CLKS_PER_BIT).
  - Reloads to 0 on every state entry and on every bit boundary.
- `tx` is registered; no combinational path from inputs to `tx`.
- `overflow` clears only on `rst`.

## Timing
- Reset values: `tx`=1, `busy`=0, `fifo_full`=0, `fifo_count`=0, `overflow`=0, FSM in IDLE, pointers 0, `strobe_q`=0.
- Reset mid-frame aborts the frame and flushes the FIFO; `tx`=1 from the cycle after `rst` is sampled.
- Write/pop latency:
  - Strobe edge sampled at cycle N → `fifo_count` increments at N+1.
  - IDLE pops at N+1 → `tx` falls at N+2.
- Frame length: 10·CLKS_PER_BIT cycles, start bit through stop bit.
- Back-to-back frames: exactly one IDLE cycle (`tx`=1) between the end of STOP and the next start bit.
- `busy` rises at N+1 after the first write. It falls the cycle after the last STOP completes, provided the FIFO is empty.
- `fifo_full` and `fifo_count` are registered and reflect the state after the previous edge.

## Test plan
- Reset: assert `rst` for 2 cycles at random FSM state → `tx`=1, `busy`=0, `fifo_count`=0, `overflow`=0.
- Single byte, CLKS_PER_BIT=4: `data_in`=0xA5, strobe pulse at cycle N → `tx` low N+2..N+5, then data bits 1,0,1,0,0,1,0,1 at 4 cycles each, then stop high 4 cycles. `busy` is low at N+42.
- Held strobe: `data_in`=0x11, `strobe_in` high for 10 cycles → exactly one frame sent, `fifo_count` peaks at 1.
- Overflow, FIFO_DEPTH=4, CLKS_PER_BIT=4: write 0x01..0x06 on strobe edges every 2 cycles →
  - 0x01 popped immediately.
  - 0x02..0x05 fill the FIFO; `fifo_full`=1.
  - 0x06 dropped; `overflow`=1.
  - Output order 0x01..0x05.
- Back-to-back: two writes 0x00 and 0xFF → after the first stop bit, exactly 1 IDLE cycle (`tx` high 5 cycles total) before the second start bit.
- Reset mid-frame: assert `rst` during DATA bit 3 with 2 bytes queued → `tx`=1 next cycle, FIFO empty. A subsequent write 0x3C transmits correctly.

Source files
------------

// File: rtl/out_port_uart_tx.sv
// 8N1 UART transmitter behind a small FIFO, fed by one CPU output port.
// Each strobe rising edge queues one byte; the FSM drains the FIFO LSB-first.
module out_port_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [7:0]                    data_in,
    input  logic                          strobe_in,
    output logic                          tx,
    output logic                          busy,
    output logic                          fifo_full,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  DEPTH_C   = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state_q, state_d;
    logic [BAUD_W-1:0]  baud_q, baud_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [7:0]         shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               strobe_q, strobe_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;

    // Small enough to live in distributed RAM; the head is read combinationally
    // so IDLE can pop straight into the shift register.
    logic [7:0]         mem [FIFO_DEPTH];

    logic strobe_edge, full, empty, pop, wr_en, bit_done;

    assign strobe_d    = strobe_in;
    assign strobe_edge = strobe_in & ~strobe_q;
    assign full        = (count_q == DEPTH_C);
    assign empty       = (count_q == '0);
    assign pop         = (state_q == IDLE) && !empty;
    assign wr_en       = strobe_edge && !full;
    assign bit_done    = (baud_q == BAUD_LAST);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | (strobe_edge & full);
        if (wr_en) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)   rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q + BAUD_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        case (state_q)
            IDLE: begin
                baud_d = '0;
                if (pop) begin
                    shift_d   = mem[rd_ptr_q];
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                if (bit_done) begin
                    baud_d    = '0;
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = STOP;
                end
            end
            STOP: begin
                if (bit_done) begin
                    baud_d  = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Line level follows the next state so tx changes on the same edge as the FSM.
        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            default: tx_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            strobe_q   <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            strobe_q   <= strobe_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr_q] <= data_in;
    end

    assign tx         = tx_q;
    assign busy       = !empty || (state_q != IDLE);
    assign fifo_full  = full;
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_out_port_uart_tx.sv
// Directed bench for out_port_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4) with a
// free-running UART receiver model that collects every frame seen on tx.
module tb_out_port_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       strobe_in;
    logic       tx, busy, fifo_full, overflow;
    logic [2:0] fifo_count;

    int checks = 0;
    int errors = 0;

    out_port_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst        (rst),
        .data_in    (data_in),
        .strobe_in  (strobe_in),
        .tx         (tx),
        .busy       (busy),
        .fifo_full  (fifo_full),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    // Receiver model: samples each bit in its middle cycle, samples taken at posedge.
    logic [7:0] rx_q[$];
    logic [7:0] rx_byte;
    bit         rx_busy = 1'b0;
    int         rx_cnt = 0;
    int         rx_frame_err = 0;
    bit         track_peak = 1'b0;
    int         peak = 0;

    always @(posedge clk) begin
        int k;
        if (track_peak && int'(fifo_count) > peak) peak = int'(fifo_count);
        if (rst === 1'b1) begin
            rx_busy = 1'b0;
        end else if (!rx_busy) begin
            if (tx === 1'b0) begin
                rx_busy = 1'b1;
                rx_cnt  = 0;
            end
        end else begin
            rx_cnt++;
            if (rx_cnt % CPB == CPB / 2) begin
                k = rx_cnt / CPB;
                if (k >= 1 && k <= 8) begin
                    rx_byte[k-1] = tx;
                end else if (k == 9) begin
                    if (tx !== 1'b1) rx_frame_err++;
                    rx_q.push_back(rx_byte);
                    rx_busy = 1'b0;
                end
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            @(negedge clk);
            c++;
        end
        check("rx_frame_count", rx_q.size(), n);
    endtask

    function automatic logic [7:0] rx_at(input int i);
        if (i < rx_q.size()) return rx_q[i];
        return 8'hxx;
    endfunction

    task automatic write_byte(input logic [7:0] b);
        @(negedge clk);
        data_in   = b;
        strobe_in = 1'b1;
        @(negedge clk);
        strobe_in = 1'b0;
    endtask

    initial begin
        int   hi, c;
        logic ok, expb;
        logic [7:0] a5;

        rst       = 1'b1;
        strobe_in = 1'b0;
        data_in   = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("reset_tx", tx, 1);
        check("reset_busy", busy, 0);
        check("reset_count", fifo_count, 0);
        check("reset_full", fifo_full, 0);
        check("reset_overflow", overflow, 0);

        // Single byte 0xA5 with exact cycle timing.
        a5 = 8'hA5;
        @(negedge clk);
        data_in   = a5;
        strobe_in = 1'b1;
        @(negedge clk);
        strobe_in = 1'b0;
        check("a5_count_n1", fifo_count, 1);
        check("a5_busy_n1", busy, 1);
        check("a5_tx_n1", tx, 1);
        @(negedge clk);
        for (int b = 0; b < 10; b++) begin
            expb = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : a5[b-1];
            ok = 1'b1;
            for (int s = 0; s < CPB; s++) begin
                if (tx !== expb) ok = 1'b0;
                @(negedge clk);
            end
            check($sformatf("a5_bit%0d", b), ok, 1);
        end
        check("a5_busy_n42", busy, 0);
        check("a5_tx_n42", tx, 1);
        check("a5_rx_count", rx_q.size(), 1);
        check("a5_rx_byte", rx_at(0), 8'hA5);

        // Held strobe writes exactly one byte.
        rx_q.delete();
        peak = 0;
        track_peak = 1'b1;
        @(negedge clk);
        data_in   = 8'h11;
        strobe_in = 1'b1;
        repeat (10) @(negedge clk);
        strobe_in = 1'b0;
        wait_rx(1, 100);
        check("held_rx_byte", rx_at(0), 8'h11);
        track_peak = 1'b0;
        check("held_peak_count", peak, 1);
        repeat (60) @(negedge clk);
        check("held_single_frame", rx_q.size(), 1);
        check("held_busy_end", busy, 0);

        // Back-to-back frames: stop bit plus one idle cycle between them.
        rx_q.delete();
        write_byte(8'h00);
        write_byte(8'hFF);
        c = 0;
        while (tx !== 1'b1 && c < 100) begin @(negedge clk); c++; end
        hi = 0;
        while (tx === 1'b1 && hi < 100) begin @(negedge clk); hi++; end
        check("b2b_high_cycles", hi, 5);
        wait_rx(2, 100);
        check("b2b_rx0", rx_at(0), 8'h00);
        check("b2b_rx1", rx_at(1), 8'hFF);

        // Overflow: 0x01 pops at once, 0x02..0x05 fill the FIFO, 0x06 is dropped.
        rx_q.delete();
        for (int i = 1; i <= 6; i++) write_byte(8'(i));
        check("ovf_full", fifo_full, 1);
        check("ovf_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        wait_rx(5, 5 * 45);
        for (int i = 0; i < 5; i++) check($sformatf("ovf_rx%0d", i), rx_at(i), 8'(i + 1));
        repeat (60) @(negedge clk);
        check("ovf_no_sixth", rx_q.size(), 5);
        check("ovf_sticky", overflow, 1);
        check("ovf_count_end", fifo_count, 0);

        // Reset during DATA bit 3 of 0xAA with 0xBB, 0xCC queued.
        rx_q.delete();
        write_byte(8'hAA);
        write_byte(8'hBB);
        write_byte(8'hCC);
        repeat (14) @(negedge clk);
        check("rmid_count_before", fifo_count, 2);
        check("rmid_busy_before", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rmid_tx", tx, 1);
        check("rmid_count", fifo_count, 0);
        check("rmid_busy", busy, 0);
        check("rmid_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        check("rmid_flushed", rx_q.size(), 0);
        check("rmid_tx_idle", tx, 1);
        write_byte(8'h3C);
        wait_rx(1, 100);
        check("rmid_rx_3c", rx_at(0), 8'h3C);
        check("stop_bit_errors", rx_frame_err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
